// File: rtl/sine_sample_gen_if.sv
// ---------------------------------------------------------------------------
// sine_sample_gen_if
//   Sample stream from the sine NCO to the DAC serializer.
//
//   Handshake: a sample moves on every rising clk edge where sample_valid and
//   sample_ready are both high. The master keeps sample_data stable while
//   sample_valid is high and sample_ready is low, and never waits for
//   sample_ready before raising sample_valid. The slave may drive sample_ready
//   at any time, independent of sample_valid.
//
//   Signals
//     sample_data   master->slave  DATA_W  offset-binary sample
//     sample_valid  master->slave  1       sample_data holds an untransferred sample
//     sample_ready  slave->master  1       slave accepts a sample this cycle
// ---------------------------------------------------------------------------
interface sine_sample_gen_if #(
  parameter int DATA_W = 12
);
  logic [DATA_W-1:0] sample_data;
  logic              sample_valid;
  logic              sample_ready;

  modport master (
    output sample_data,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample_data,
    input  sample_valid,
    output sample_ready
  );
endinterface

// File: rtl/sine_sample_gen.sv
// ---------------------------------------------------------------------------
// sine_sample_gen
//   Phase-accumulator NCO with a quarter-wave sine LUT. One offset-binary
//   sample is launched every SAMPLE_DIV clocks and handed to the DAC
//   serializer over a valid/ready stream. Ticks that cannot be accepted are
//   dropped and counted.
//
//   Ports
//     clk          in   system clock
//     rst_n        in   synchronous active-low reset
//     en           in   run enable; low holds phase and flushes the output
//     phase_inc    in   phase step per tick, sampled at the tick
//     smp          if   sample stream (master side)
//     overrun      out  sticky: at least one tick was dropped
//     overrun_cnt  out  dropped-tick count, saturates at 255
//
//   Pipeline from a tick in cycle t:
//     t+1  s1 holds the pre-increment phase; quadrant and LUT index decoded
//     t+2  s2 holds the registered LUT word and the sign of the half-wave
//     t+3  sample_data / sample_valid registered
//   The LUT table is fixed for LUT_AW = 6 and DATA_W = 12.
// ---------------------------------------------------------------------------
module sine_sample_gen #(
  parameter int DATA_W     = 12,
  parameter int PHASE_W    = 24,
  parameter int LUT_AW     = 6,
  parameter int SAMPLE_DIV = 650
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [PHASE_W-1:0]   phase_inc,
  sine_sample_gen_if.master    smp,
  output logic                 overrun,
  output logic [7:0]           overrun_cnt
);

  localparam int                CNT_W    = $clog2(SAMPLE_DIV);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SAMPLE_DIV - 1);
  localparam logic [DATA_W-1:0] MID      = DATA_W'(1 << (DATA_W - 1));
  localparam int                S1_W     = LUT_AW + 2;

  // lut[k] = round(2047 * sin(pi/2 * (k + 0.5) / 64))
  localparam logic [DATA_W-2:0] LUT [64] = '{
    11'd25,   11'd75,   11'd126,  11'd176,  11'd226,  11'd275,  11'd325,  11'd375,
    11'd424,  11'd473,  11'd522,  11'd570,  11'd618,  11'd666,  11'd713,  11'd760,
    11'd807,  11'd852,  11'd898,  11'd943,  11'd987,  11'd1031, 11'd1074, 11'd1116,
    11'd1158, 11'd1199, 11'd1239, 11'd1279, 11'd1318, 11'd1356, 11'd1393, 11'd1430,
    11'd1465, 11'd1500, 11'd1533, 11'd1566, 11'd1598, 11'd1629, 11'd1659, 11'd1688,
    11'd1716, 11'd1743, 11'd1769, 11'd1793, 11'd1817, 11'd1840, 11'd1861, 11'd1881,
    11'd1901, 11'd1919, 11'd1936, 11'd1951, 11'd1966, 11'd1979, 11'd1992, 11'd2003,
    11'd2012, 11'd2021, 11'd2028, 11'd2035, 11'd2039, 11'd2043, 11'd2046, 11'd2047
  };

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               en_prev_q, en_prev_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               s1_vld_q, s1_vld_d;
  logic [S1_W-1:0]    s1_p_q, s1_p_d;     // quadrant + LUT address bits of p
  logic               s2_vld_q, s2_vld_d;
  logic [DATA_W-2:0]  s2_lut_q, s2_lut_d;
  logic               s2_neg_q, s2_neg_d; // lower half-wave (q2/q3)
  logic [DATA_W-1:0]  data_q, data_d;
  logic               valid_q, valid_d;
  logic               ovr_q, ovr_d;
  logic [7:0]         ovr_cnt_q, ovr_cnt_d;

  logic               tick, xfer, drop, accept;
  logic [1:0]         quad;
  logic [LUT_AW-1:0]  addr, idx;
  logic [DATA_W-1:0]  mapped;

  always_comb begin
    tick   = en && (cnt_q == CNT_LAST);
    xfer   = valid_q && smp.sample_ready;
    // A tick is only taken if it cannot collide with work already in flight.
    drop   = tick && (s1_vld_q || s2_vld_q || (valid_q && !smp.sample_ready));
    accept = tick && !drop;

    // The cycle en rises still holds the counter at 0, so the first tick
    // lands SAMPLE_DIV cycles after that cycle.
    cnt_d     = '0;
    if (en && en_prev_q) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    end
    en_prev_d = en;

    phase_d  = tick ? phase_q + phase_inc : phase_q;

    s1_vld_d = accept;
    s1_p_d   = accept ? phase_q[PHASE_W-1 -: S1_W] : s1_p_q;

    // Odd quadrants run the quarter-wave table backwards.
    quad     = s1_p_q[S1_W-1 -: 2];
    addr     = s1_p_q[LUT_AW-1:0];
    idx      = quad[0] ? ~addr : addr;

    s2_vld_d = en && s1_vld_q;
    s2_lut_d = s1_vld_q ? LUT[idx] : s2_lut_q;
    s2_neg_d = s1_vld_q ? quad[1] : s2_neg_q;

    mapped   = s2_neg_q ? (MID - DATA_W'(1)) - {1'b0, s2_lut_q}
                        : MID + {1'b0, s2_lut_q};

    valid_d  = en && (s2_vld_q || (valid_q && !xfer));
    data_d   = (en && s2_vld_q) ? mapped : data_q;

    ovr_d     = ovr_q || drop;
    ovr_cnt_d = (drop && ovr_cnt_q != 8'hFF) ? ovr_cnt_q + 8'd1 : ovr_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      en_prev_q <= 1'b0;
      phase_q   <= '0;
      s1_vld_q  <= 1'b0;
      s1_p_q    <= '0;
      s2_vld_q  <= 1'b0;
      s2_lut_q  <= '0;
      s2_neg_q  <= 1'b0;
      data_q    <= MID;
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
      ovr_cnt_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      en_prev_q <= en_prev_d;
      phase_q   <= phase_d;
      s1_vld_q  <= s1_vld_d;
      s1_p_q    <= s1_p_d;
      s2_vld_q  <= s2_vld_d;
      s2_lut_q  <= s2_lut_d;
      s2_neg_q  <= s2_neg_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ovr_q     <= ovr_d;
      ovr_cnt_q <= ovr_cnt_d;
    end
  end

  assign smp.sample_data  = data_q;
  assign smp.sample_valid = valid_q;
  assign overrun          = ovr_q;
  assign overrun_cnt      = ovr_cnt_q;

endmodule
